// File: rtl/psg_wave_fetch_pkg.sv
// Shared constants, FSM state type and one-hot helper for psg_wave_fetch.
// Build option: PSG_FETCH_TIMEOUT_EN enables the bus wait limit.
package psg_fetch_pkg;

   localparam int NCH = 8;
   localparam int CHW = 3;
   localparam int TO_CYCLES_DEF = 63;

   typedef enum logic [1:0] {
      ARB,
      LATCH,
      BUS
   } state_t;

   function automatic logic [NCH-1:0] chan_oh(
      input logic [CHW-1:0] c
   );
      return NCH'(1) << c;
   endfunction

endpackage

// File: rtl/psg_wave_fetch_if.sv
// System bus read port used by the wave fetch unit.
// Ports: cyc_o/stb_o/adr_o from master, dat_i/ack_i from slave.
interface psg_wave_fetch_if #(
   parameter int AW = 24,
   parameter int DW = 16
);

   logic          cyc_o;
   logic          stb_o;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_i;
   logic          ack_i;

   modport master (
      output cyc_o,
      output stb_o,
      output adr_o,
      input  dat_i,
      input  ack_i
   );

   modport slave (
      input  cyc_o,
      input  stb_o,
      input  adr_o,
      output dat_i,
      output ack_i
   );

endinterface

// File: rtl/psg_wave_fetch_adr_mux.sv
// Combinational 8:1 channel address mux.
// Ports: i ch_adr (8 packed AW-bit), seln; o adr.
module psg_chan_adr_mux
   import psg_fetch_pkg::*;
#(
   parameter int AW = 24
) (
   input  logic [NCH*AW-1:0] ch_adr,
   input  logic [CHW-1:0]    seln,
   output logic [AW-1:0]     adr
);

   assign adr = ch_adr[seln*AW +: AW];

endmodule

// File: rtl/psg_wave_fetch.sv
// Bus-side fetch for the PSG arbiter grant; acks arbiter, reads sample.
// Ports: clk/rst/ce, seln/sel_any, ch_req/ch_adr, arb_ack, bus (master),
// ch_dat/ch_vld/ch_err, busy. Option: PSG_FETCH_TIMEOUT_EN.
module psg_wave_fetch
   import psg_fetch_pkg::*;
#(
   parameter int AW        = 24,
   parameter int DW        = 16,
   parameter int TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [CHW-1:0]    seln,
   input  logic              sel_any,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*AW-1:0] ch_adr,
   output logic              arb_ack,
   psg_wave_fetch_if.master  bus,
   output logic [DW-1:0]     ch_dat,
   output logic [NCH-1:0]    ch_vld,
   output logic [NCH-1:0]    ch_err,
   output logic              busy
);

   state_t          r_state;
   state_t          w_nxt;
   logic [CHW-1:0]  r_chan;
   logic [DW-1:0]   r_dat;
   logic [NCH-1:0]  r_vld;
   logic [NCH-1:0]  r_err;
   logic [AW-1:0]   w_adr;
   logic            w_start;
   logic            w_done;
   logic            w_tmo;
   logic            w_tmo_hit;
   logic            w_ack;
   logic            w_busy;

   psg_chan_adr_mux #(.AW(AW)) u_mux (
      .ch_adr (ch_adr),
      .seln   (seln),
      .adr    (w_adr)
   );

`ifdef PSG_FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_start) begin
         r_cnt <= '0;
      end else if (r_state == BUS && !bus.ack_i) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Fires on the wait cycle that brings the count to TO_CYCLES.
   assign w_tmo_hit = (r_state == BUS) && !bus.ack_i &&
                      (r_cnt == CW'(TO_CYCLES - 1));
`else
   logic w_unused_to;
   assign w_unused_to = ^TO_CYCLES;
   assign w_tmo_hit   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ARB;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt   = r_state;
      w_ack   = 1'b0;
      w_busy  = 1'b0;
      w_start = 1'b0;
      w_done  = 1'b0;
      w_tmo   = 1'b0;
      unique case (r_state)
         ARB: begin
            w_ack = 1'b1;
            if (ce) w_nxt = LATCH;
         end
         LATCH: begin
            w_busy = 1'b1;
            // Arbiter keeps a stale owner when idle; reject it here.
            if (sel_any && ch_req[seln]) begin
               w_start = 1'b1;
               w_nxt   = BUS;
            end else begin
               w_nxt = ARB;
            end
         end
         BUS: begin
            w_busy = 1'b1;
            if (bus.ack_i) begin
               w_done = 1'b1;
               w_nxt  = ARB;
            end else if (w_tmo_hit) begin
               w_tmo = 1'b1;
               w_nxt = ARB;
            end
         end
         default: w_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chan    <= '0;
         r_dat     <= '0;
         r_vld     <= '0;
         r_err     <= '0;
         bus.cyc_o <= 1'b0;
         bus.stb_o <= 1'b0;
         bus.adr_o <= '0;
      end else begin
         r_vld <= '0;
         r_err <= '0;
         if (w_start) begin
            r_chan    <= seln;
            bus.adr_o <= w_adr;
            bus.cyc_o <= 1'b1;
            bus.stb_o <= 1'b1;
         end
         if (w_done) begin
            r_dat     <= bus.dat_i;
            r_vld     <= chan_oh(r_chan);
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
         end
         if (w_tmo) begin
            r_dat     <= '0;
            r_err     <= chan_oh(r_chan);
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
         end
      end
   end

   assign arb_ack = w_ack;
   assign busy    = w_busy;
   assign ch_dat  = r_dat;
   assign ch_vld  = r_vld;
   assign ch_err  = r_err;

endmodule
